// File: rtl/threedeeo_pkg.sv
// Shared constants and state encoding for the 3DO controller chain sequencer.
package threedeeo_pkg;
    localparam int unsigned PAD_BITS = 16;
    localparam int unsigned MAX_PADS = 4;
    localparam logic        EOC_BIT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        DONE
    } chain_state_t;
endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin with registered level and edge strobes.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic system_clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;

    // level is the delayed copy so it lines up with the registered edge strobes
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VALUE}};
            level <= RESET_VALUE;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            level <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~level;
            fall  <= ~chain[SYNC_STAGES-1] & level;
        end
    end
endmodule

// File: rtl/threedeeo_chain_sched.sv
// 3DO controller daisy-chain sequencer: snapshots pad words at frame start and
// serializes the present pads MSB first, followed by end-of-chain zeros.
module threedeeo_chain_sched
    import threedeeo_pkg::*;
#(
    parameter int unsigned NUM_PADS    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 20000
) (
    input  logic                         system_clock,
    input  logic                         reset,
    input  logic                         clk,
    input  logic                         ps,
    output logic                         dat,
    input  logic [NUM_PADS*PAD_BITS-1:0] pad_word,
    input  logic [NUM_PADS-1:0]          pad_valid,
    input  logic [NUM_PADS-1:0]          pad_remove,
    output logic [NUM_PADS-1:0]          present,
    output logic                         frame_done,
    output logic                         timeout_err
);
    localparam int unsigned CNT_W = $clog2(NUM_PADS*PAD_BITS + 1);
    localparam int unsigned BIT_W = $clog2(PAD_BITS);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef logic [PAD_BITS-1:0] word_arr_t [NUM_PADS];

    word_arr_t             pad_in;
    word_arr_t             shadow;
    word_arr_t             snap;
    logic [NUM_PADS-1:0]   snap_present;
    logic [CNT_W-1:0]      total_bits;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WD_W-1:0]       wdog;
    chain_state_t          state;

    logic clk_level_unused, clk_rise_unused, clk_fall;
    logic ps_level, ps_rise, ps_fall;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_unpack
        assign pad_in[g] = pad_word[g*PAD_BITS +: PAD_BITS];
    end

    edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_clk_sync (
        .system_clock (system_clock),
        .reset        (reset),
        .pin          (clk),
        .level        (clk_level_unused),
        .rise         (clk_rise_unused),
        .fall         (clk_fall)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_ps_sync (
        .system_clock (system_clock),
        .reset        (reset),
        .pin          (ps),
        .level        (ps_level),
        .rise         (ps_rise),
        .fall         (ps_fall)
    );

    // Bit idx of the chain stream: slot ordinal idx/PAD_BITS among present slots, MSB first.
    function automatic logic stream_bit(input word_arr_t words,
                                        input logic [NUM_PADS-1:0] mask,
                                        input logic [CNT_W-1:0] idx);
        logic        bit_val;
        int unsigned ord;
        int unsigned slot_ord;
        bit_val  = EOC_BIT;
        ord      = 0;
        slot_ord = 32'(idx >> BIT_W);
        for (int unsigned n = 0; n < NUM_PADS; n++) begin
            if (mask[n]) begin
                if (ord == slot_ord) bit_val = words[n][~idx[BIT_W-1:0]];
                ord++;
            end
        end
        return bit_val;
    endfunction

    function automatic logic [CNT_W-1:0] chain_bits(input logic [NUM_PADS-1:0] mask);
        int unsigned n_present;
        n_present = 0;
        for (int unsigned n = 0; n < NUM_PADS; n++) begin
            if (mask[n]) n_present++;
        end
        return CNT_W'(n_present * PAD_BITS);
    endfunction

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            present <= '0;
            for (int unsigned n = 0; n < NUM_PADS; n++) shadow[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_PADS; n++) begin
                if (pad_valid[n]) begin
                    shadow[n]  <= pad_in[n];
                    present[n] <= 1'b1;
                end else if (pad_remove[n]) begin
                    present[n] <= 1'b0;
                end
            end
        end
    end

    // ps edges take priority; a clk edge in the same cycle is dropped
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dat          <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            bit_cnt      <= '0;
            total_bits   <= '0;
            wdog         <= '0;
            snap_present <= '0;
            for (int unsigned n = 0; n < NUM_PADS; n++) snap[n] <= '0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            if (ps_rise) begin
                state <= IDLE;
                dat   <= stream_bit(snap, snap_present, '0);
            end else if (state == IDLE) begin
                if (ps_fall) begin
                    snap         <= shadow;
                    snap_present <= present;
                    total_bits   <= chain_bits(present);
                    bit_cnt      <= '0;
                    wdog         <= '0;
                    dat          <= stream_bit(shadow, present, '0);
                    state        <= ARM;
                end else begin
                    dat <= stream_bit(snap, snap_present, '0);
                end
            end else begin
                if (clk_fall) wdog <= '0;
                else if (!ps_level) wdog <= wdog + 1'b1;

                if (!clk_fall && !ps_level && wdog == WD_LAST) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                    dat         <= stream_bit(snap, snap_present, '0);
                end else begin
                    case (state)
                        ARM: state <= SHIFT;
                        SHIFT: begin
                            if (clk_fall) begin
                                if (bit_cnt == total_bits) begin
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                    dat        <= EOC_BIT;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    dat     <= stream_bit(snap, snap_present, bit_cnt + 1'b1);
                                end
                            end
                        end
                        default: dat <= EOC_BIT;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_threedeeo_chain_sched.sv
// Directed bench for the 3DO chain sequencer: frames, presence changes, aborts and reset.
module tb_threedeeo_chain_sched;
    import threedeeo_pkg::*;

    localparam int unsigned HALF = 8;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        con_clk;
    logic        con_ps;
    logic        dat;
    logic [31:0] pad_word;
    logic [1:0]  pad_valid;
    logic [1:0]  pad_remove;
    logic [1:0]  present;
    logic        frame_done;
    logic        timeout_err;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int to_cnt     = 0;

    threedeeo_chain_sched #(.NUM_PADS(2), .SYNC_STAGES(2), .TIMEOUT(200)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .clk          (con_clk),
        .ps           (con_ps),
        .dat          (dat),
        .pad_word     (pad_word),
        .pad_valid    (pad_valid),
        .pad_remove   (pad_remove),
        .present      (present),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #25 system_clock = ~system_clock;

    always @(negedge system_clock) begin
        if (frame_done)  done_cnt++;
        if (timeout_err) to_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_pad(input int slot, input logic [15:0] w);
        pad_word[slot*16 +: 16] = w;
        pad_valid[slot] = 1'b1;
        tick(1);
        pad_valid = '0;
    endtask

    // wr_at: -1 no write, -2 write slot0 in the snapshot cycle, else before that pulse
    task automatic run_frame(input int npulses, input int wr_at, input logic [15:0] wr_word,
                             output logic [63:0] bits, output int done_at, output int done_n);
        int base;
        base    = done_cnt;
        bits    = '0;
        done_at = 0;
        con_ps  = 1'b0;
        if (wr_at == -2) begin
            tick(3);
            pad_word[15:0] = wr_word;
            pad_valid[0]   = 1'b1;
            tick(1);
            pad_valid[0]   = 1'b0;
            tick(6);
        end else begin
            tick(10);
        end
        for (int i = 0; i < npulses; i++) begin
            if (i == wr_at) write_pad(0, wr_word);
            bits = {bits[62:0], dat};
            con_clk = 1'b0;
            tick(HALF);
            con_clk = 1'b1;
            tick(HALF);
            if (done_at == 0 && done_cnt != base) done_at = i + 1;
        end
        con_ps = 1'b1;
        tick(10);
        done_n = done_cnt - base;
    endtask

    initial begin
        logic [63:0] bits;
        int          done_at;
        int          done_n;
        int          to_base;
        int          done_base;

        reset      = 1'b1;
        con_clk    = 1'b1;
        con_ps     = 1'b1;
        pad_word   = '0;
        pad_valid  = '0;
        pad_remove = '0;
        tick(3);
        reset = 1'b0;
        tick(3);

        check("reset_dat",     64'(dat),         64'd0);
        check("reset_present", 64'(present),     64'd0);
        check("reset_done",    64'(frame_done),  64'd0);
        check("reset_timeout", 64'(timeout_err), 64'd0);
        check("reset_state",   64'(dut.state),   64'(IDLE));

        write_pad(0, 16'hC006);
        check("present_one", 64'(present), 64'h1);
        run_frame(32, -1, 16'h0, bits, done_at, done_n);
        check("one_pad_bits",    bits,          64'h0000_0000_C006_0000);
        check("one_pad_done_at", 64'(done_at),  64'd17);
        check("one_pad_done_n",  64'(done_n),   64'd1);

        write_pad(1, 16'h8001);
        check("present_two", 64'(present), 64'h3);
        run_frame(40, -1, 16'h0, bits, done_at, done_n);
        check("two_pad_bits",    bits,         64'h0000_00C0_0680_0100);
        check("two_pad_done_at", 64'(done_at), 64'd33);
        check("two_pad_done_n",  64'(done_n),  64'd1);
        run_frame(40, -1, 16'h0, bits, done_at, done_n);
        check("repeat_bits",    bits,         64'h0000_00C0_0680_0100);
        check("repeat_done_n",  64'(done_n),  64'd1);

        pad_remove[0] = 1'b1;
        tick(1);
        pad_remove[0] = 1'b0;
        check("present_removed", 64'(present), 64'h2);
        run_frame(24, -1, 16'h0, bits, done_at, done_n);
        check("removed_bits",    bits,         64'h0000_0000_0080_0100);
        check("removed_done_at", 64'(done_at), 64'd17);

        write_pad(0, 16'hC006);
        run_frame(40, 5, 16'hFFFF, bits, done_at, done_n);
        check("midwrite_cur_bits", bits, 64'h0000_00C0_0680_0100);
        run_frame(40, -1, 16'h0, bits, done_at, done_n);
        check("midwrite_next_bits", bits, 64'h0000_00FF_FF80_0100);
        run_frame(40, -2, 16'h1234, bits, done_at, done_n);
        check("armwrite_cur_bits", bits, 64'h0000_00FF_FF80_0100);
        run_frame(40, -1, 16'h0, bits, done_at, done_n);
        check("armwrite_next_bits", bits, 64'h0000_0012_3480_0100);

        run_frame(7, -1, 16'h0, bits, done_at, done_n);
        check("abort_bits",   bits,           64'h9);
        check("abort_done_n", 64'(done_n),    64'd0);
        check("abort_state",  64'(dut.state), 64'(IDLE));
        run_frame(40, -1, 16'h0, bits, done_at, done_n);
        check("after_abort_bits",    bits,         64'h0000_0012_3480_0100);
        check("after_abort_done_at", 64'(done_at), 64'd33);
        check("no_timeouts_yet",     64'(to_cnt),  64'd0);

        to_base   = to_cnt;
        done_base = done_cnt;
        con_ps = 1'b0;
        tick(8);
        check("wd_state_shift", 64'(dut.state), 64'(SHIFT));
        tick(192);
        check("wd_before_expiry", 64'(to_cnt - to_base), 64'd0);
        tick(6);
        check("wd_one_pulse", 64'(to_cnt - to_base), 64'd1);
        check("wd_state_idle", 64'(dut.state), 64'(IDLE));
        tick(300);
        check("wd_no_rearm", 64'(to_cnt - to_base), 64'd1);
        check("wd_no_done", 64'(done_cnt - done_base), 64'd0);
        con_ps = 1'b1;
        tick(10);

        done_base = done_cnt;
        to_base   = to_cnt;
        con_ps = 1'b0;
        tick(10);
        for (int i = 0; i < 3; i++) begin
            con_clk = 1'b0;
            tick(HALF);
            con_clk = 1'b1;
            tick(HALF);
        end
        check("pre_reset_dat", 64'(dat), 64'd1);
        #7 reset = 1'b1;
        #1;
        check("async_reset_dat",     64'(dat),       64'd0);
        check("async_reset_present", 64'(present),   64'd0);
        check("async_reset_state",   64'(dut.state), 64'(IDLE));
        con_ps = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(20);
        check("reset_no_done",    64'(done_cnt - done_base), 64'd0);
        check("reset_no_timeout", 64'(to_cnt - to_base),     64'd0);
        check("post_reset_dat",   64'(dat),                  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
